button_conditioner: RTL and testbench

Input front end for the ship controller. Synchronises the raw left, right and fire push-buttons to `clk_12MHz`, debounces each one, and produces three outputs: clean level outputs, a one-cycle `move_enable` strobe with hold-to-auto-repeat, and a one-cycle `fire_pulse` per fire press. `left_debounced`, `right_debounced` and `move_enable` connect directly to the ship position register's `left_debounced`, `right_debounced` and `enable` inputs.

---
 rtl/button_conditioner.sv | 174 +++++++++++++++++
 tb/tb_button_conditioner.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Button front end: 2-flop sync + debounce per button, move strobe with hold-to-repeat, fire strobe.
// Levels lag raw by DEBOUNCE_CYCLES+1 edges after first sample; strobes follow one cycle later. No backpressure.

module button_channel #(
  parameter int DEBOUNCE_CYCLES = 120000
) (
  input  logic clk_12MHz,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  // Counter only runs while the synchronised input disagrees with the accepted level
  always_ff @(posedge clk_12MHz) begin
    if (reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int REPEAT_DELAY    = 3600000,
  parameter int REPEAT_RATE     = 1200000
) (
  input  logic clk_12MHz,
  input  logic reset,
  input  logic left_raw,
  input  logic right_raw,
  input  logic fire_raw,
  output logic left_debounced,
  output logic right_debounced,
  output logic fire_debounced,
  output logic move_enable,
  output logic fire_pulse
);

  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = (RMAX > 2) ? $clog2(RMAX) : 1;
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [RW-1:0] rcnt;
  logic [RW-1:0] rcnt_n;
  logic          pulse_n;
  logic          left_prev;
  logic          right_prev;
  logic          fire_prev;
  logic          held;
  logic          press;

  button_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left (
    .clk_12MHz (clk_12MHz),
    .reset     (reset),
    .raw       (left_raw),
    .level     (left_debounced)
  );

  button_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right (
    .clk_12MHz (clk_12MHz),
    .reset     (reset),
    .raw       (right_raw),
    .level     (right_debounced)
  );

  button_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_fire (
    .clk_12MHz (clk_12MHz),
    .reset     (reset),
    .raw       (fire_raw),
    .level     (fire_debounced)
  );

  assign held  = left_debounced | right_debounced;
  // A same-cycle left->right swap keeps held high and shows up here as a press
  assign press = (left_debounced & ~left_prev) | (right_debounced & ~right_prev);

  always_comb begin
    state_n = state;
    rcnt_n  = rcnt;
    pulse_n = 1'b0;
    case (state)
      IDLE: begin
        if (press) begin
          pulse_n = 1'b1;
          rcnt_n  = '0;
          state_n = DELAY;
        end
      end
      DELAY: begin
        if (!held) begin
          state_n = IDLE;
        end else if (press) begin
          pulse_n = 1'b1;
          rcnt_n  = '0;
        end else if (rcnt == DELAY_LAST) begin
          pulse_n = 1'b1;
          rcnt_n  = '0;
          state_n = REPEAT;
        end else begin
          rcnt_n = rcnt + RW'(1);
        end
      end
      REPEAT: begin
        if (!held) begin
          state_n = IDLE;
        end else if (press) begin
          pulse_n = 1'b1;
          rcnt_n  = '0;
          state_n = DELAY;
        end else if (rcnt == RATE_LAST) begin
          pulse_n = 1'b1;
          rcnt_n  = '0;
        end else begin
          rcnt_n = rcnt + RW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        rcnt_n  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_12MHz) begin
    if (reset) begin
      state       <= IDLE;
      rcnt        <= '0;
      move_enable <= 1'b0;
      fire_pulse  <= 1'b0;
      left_prev   <= 1'b0;
      right_prev  <= 1'b0;
      fire_prev   <= 1'b0;
    end else begin
      state       <= state_n;
      rcnt        <= rcnt_n;
      move_enable <= pulse_n;
      fire_pulse  <= fire_debounced & ~fire_prev;
      left_prev   <= left_debounced;
      right_prev  <= right_debounced;
      fire_prev   <= fire_debounced;
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed vector table, multi-cycle sequences, randomized run against a cycle-arithmetic reference model.
module tb_button_conditioner;

  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RR = 5;

  logic clk_12MHz = 1'b0;
  logic reset     = 1'b1;
  logic left_raw  = 1'b0;
  logic right_raw = 1'b0;
  logic fire_raw  = 1'b0;
  logic left_debounced, right_debounced, fire_debounced, move_enable, fire_pulse;

  button_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY    (RD),
    .REPEAT_RATE     (RR)
  ) dut (
    .clk_12MHz       (clk_12MHz),
    .reset           (reset),
    .left_raw        (left_raw),
    .right_raw       (right_raw),
    .fire_raw        (fire_raw),
    .left_debounced  (left_debounced),
    .right_debounced (right_debounced),
    .fire_debounced  (fire_debounced),
    .move_enable     (move_enable),
    .fire_pulse      (fire_pulse)
  );

  always #5 clk_12MHz = ~clk_12MHz;

  int n_tests = 0;
  int n_fail  = 0;
  int edge_n  = 0;
  int me_q[$];
  int fp_q[$];
  int exp_q[$];

  // Reference model: per-button stable-run counting, repeat timing from absolute strobe times
  logic m_s1[3], m_s2[3], m_lvl[3], m_prev[3];
  int   m_run[3];
  logic m_me, m_fp, m_active;
  int   m_last, m_nrep, m_cyc;

  task automatic model_step();
    logic raw[3];
    logic press, held, me_n, fp_n;
    raw[0] = left_raw; raw[1] = right_raw; raw[2] = fire_raw;
    if (reset) begin
      for (int c = 0; c < 3; c++) begin
        m_s1[c] = 0; m_s2[c] = 0; m_lvl[c] = 0; m_prev[c] = 0; m_run[c] = 0;
      end
      m_me = 0; m_fp = 0; m_active = 0; m_last = 0; m_nrep = 0;
    end else begin
      press = (m_lvl[0] & ~m_prev[0]) | (m_lvl[1] & ~m_prev[1]);
      held  = m_lvl[0] | m_lvl[1];
      me_n  = 0;
      if (!held) m_active = 0;
      else if (press) begin
        me_n = 1; m_last = m_cyc; m_nrep = 0; m_active = 1;
      end else if (m_active && (m_cyc - m_last) == ((m_nrep == 0) ? RD : RR)) begin
        me_n = 1; m_last = m_cyc; m_nrep++;
      end
      fp_n = m_lvl[2] & ~m_prev[2];
      for (int c = 0; c < 3; c++) begin
        m_prev[c] = m_lvl[c];
        if (m_s2[c] != m_lvl[c]) begin
          m_run[c]++;
          if (m_run[c] == D) begin
            m_lvl[c] = ~m_lvl[c];
            m_run[c] = 0;
          end
        end else m_run[c] = 0;
        m_s2[c] = m_s1[c];
        m_s1[c] = raw[c];
      end
      m_me = me_n;
      m_fp = fp_n;
    end
    m_cyc++;
  endtask

  task automatic tick();
    logic [4:0] got, exp;
    @(posedge clk_12MHz);
    model_step();
    #1;
    edge_n++;
    if (move_enable) me_q.push_back(edge_n);
    if (fire_pulse)  fp_q.push_back(edge_n);
    got = {left_debounced, right_debounced, fire_debounced, move_enable, fire_pulse};
    exp = {m_lvl[0], m_lvl[1], m_lvl[2], m_me, m_fp};
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL model cyc=%0d got=%b exp=%b (ld rd fd me fp)", m_cyc, got, exp);
    end
  endtask

  task automatic run_to(input int n);
    while (edge_n < n) tick();
  endtask

  // Last reset edge becomes edge 0; buttons set by the caller are first sampled at edge 1
  task automatic do_reset();
    reset = 1; left_raw = 0; right_raw = 0; fire_raw = 0;
    tick(); tick();
    reset = 0;
    edge_n = 0;
    me_q.delete(); fp_q.delete();
  endtask

  function automatic string q2s(input int sel);
    string s = "";
    if (sel == 0) foreach (me_q[i]) s = $sformatf("%s %0d", s, me_q[i]);
    else if (sel == 1) foreach (fp_q[i]) s = $sformatf("%s %0d", s, fp_q[i]);
    else foreach (exp_q[i]) s = $sformatf("%s %0d", s, exp_q[i]);
    return s;
  endfunction

  task automatic check_q(input string name, input int sel);
    logic ok;
    ok = 1;
    if (sel == 0) begin
      if (me_q.size() != exp_q.size()) ok = 0;
      else foreach (me_q[i]) if (me_q[i] != exp_q[i]) ok = 0;
    end else begin
      if (fp_q.size() != exp_q.size()) ok = 0;
      else foreach (fp_q[i]) if (fp_q[i] != exp_q[i]) ok = 0;
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s edges got{%s } exp{%s }", name, q2s(sel), q2s(2));
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  typedef struct {
    logic       rst;
    logic [2:0] btn;   // {fire, right, left}
    logic [4:0] exp;   // {ld, rd, fd, me, fp}
  } vec_t;

  vec_t vecs[11];

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int e3[7];
    int e4[7];
    int fall_e, rise_e;
    logic prev_rd, saw, zero_ok;
    logic [4:0] got;

    for (int c = 0; c < 3; c++) begin
      m_s1[c] = 0; m_s2[c] = 0; m_lvl[c] = 0; m_prev[c] = 0; m_run[c] = 0;
    end
    m_me = 0; m_fp = 0; m_active = 0; m_last = 0; m_nrep = 0; m_cyc = 0;

    // Test 1: reset with left held, then left accepted at edge 6 and strobe at edge 7
    vecs[0]  = '{1'b1, 3'b001, 5'b00000};
    vecs[1]  = '{1'b1, 3'b001, 5'b00000};
    for (int i = 2; i < 11; i++) vecs[i] = '{1'b0, 3'b001, 5'b00000};
    vecs[7].exp = 5'b10000;
    vecs[8].exp = 5'b10010;
    vecs[9].exp = 5'b10000;
    vecs[10].exp = 5'b10000;
    for (int i = 0; i < 11; i++) begin
      reset = vecs[i].rst;
      {fire_raw, right_raw, left_raw} = vecs[i].btn;
      tick();
      got = {left_debounced, right_debounced, fire_debounced, move_enable, fire_pulse};
      n_tests++;
      if (got !== vecs[i].exp) begin
        n_fail++;
        $display("FAIL vec%0d got=%b exp=%b", i, got, vecs[i].exp);
      end
    end

    // Test 2: 2-cycle bounce never accepted
    do_reset();
    saw = 0;
    for (int k = 0; k < 40; k++) begin
      left_raw = ((k / 2) % 2) == 0;
      tick();
      if (left_debounced || move_enable) saw = 1;
    end
    left_raw = 0;
    repeat (10) begin
      tick();
      if (left_debounced || move_enable) saw = 1;
    end
    check_int("bounce_rejected", int'(saw), 0);

    // Test 3: hold right for 40 cycles, auto-repeat, release
    do_reset();
    right_raw = 1;
    run_to(40);
    right_raw = 0;
    fall_e = -1;
    prev_rd = right_debounced;
    while (edge_n < 60) begin
      tick();
      if (prev_rd && !right_debounced && fall_e < 0) fall_e = edge_n;
      prev_rd = right_debounced;
    end
    e3 = '{7, 17, 22, 27, 32, 37, 42};
    exp_q.delete(); foreach (e3[i]) exp_q.push_back(e3[i]);
    check_q("hold_repeat", 0);
    check_int("right_fall_edge", fall_e, 46);
    right_raw = 1;
    run_to(67);
    check_int("idle_after_release", int'(move_enable), 1);

    // Test 4: left held into REPEAT, then swap to right in one cycle
    do_reset();
    left_raw = 1;
    run_to(24);
    left_raw = 0; right_raw = 1;
    run_to(50);
    e4 = '{7, 17, 22, 27, 31, 41, 46};
    exp_q.delete(); foreach (e4[i]) exp_q.push_back(e4[i]);
    check_q("swap_restart", 0);
    check_int("swap_held_right", int'(right_debounced), 1);

    // Test 5: fire held for 50 cycles gives one pulse at edge 7
    do_reset();
    fire_raw = 1;
    run_to(50);
    fire_raw = 0;
    run_to(60);
    exp_q.delete(); exp_q.push_back(7);
    check_q("fire_single", 1);
    exp_q.delete();
    check_q("fire_no_move", 0);

    // Test 6: one-cycle reset while left held in REPEAT
    do_reset();
    left_raw = 1;
    run_to(25);
    reset = 1;
    tick();
    zero_ok = !(left_debounced | right_debounced | fire_debounced | move_enable | fire_pulse);
    check_int("midreset_outputs_zero", int'(zero_ok), 1);
    reset = 0;
    edge_n = 0; me_q.delete(); fp_q.delete();
    rise_e = -1;
    while (edge_n < 12) begin
      tick();
      if (left_debounced && rise_e < 0) rise_e = edge_n;
    end
    exp_q.delete(); exp_q.push_back(7);
    check_q("midreset_restrobe", 0);
    check_int("midreset_left_rise", rise_e, 6);

    // Randomized run: model compares every cycle inside tick()
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(15) == 0) left_raw  = ~left_raw;
      if ($urandom_range(15) == 0) right_raw = ~right_raw;
      if ($urandom_range(15) == 0) fire_raw  = ~fire_raw;
      reset = ($urandom_range(399) == 0);
      tick();
    end
    reset = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
